// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the branch/PC unit.
// FSM state encoding, branch funct3 codes, vector defaults.
package rv32_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_TRAP  = 2'd3
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

   // Saturating increment for the 32-bit perf counters
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/br_cond.sv
// br_cond: branch condition evaluation from funct3 and
// comparator flags; flags reserved funct3 encodings.
module br_cond
   import rv32_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       eq_i,
   input  logic       lt_i,
   output logic       taken_o,
   output logic       illegal_o
);

   // Decode funct3 into a taken decision or an illegal flag
   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      unique case (funct3_i)
         F3_BEQ:  taken_o = eq_i;
         F3_BNE:  taken_o = !eq_i;
         F3_BLT:  taken_o = lt_i;
         F3_BGE:  taken_o = !lt_i;
         F3_BLTU: taken_o = lt_i;
         F3_BGEU: taken_o = !lt_i;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC sequencer with fetch handshake, branch and
// jump resolution, misaligned-target trap and perf counters.
module branch_pc_unit
   import rv32_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
   parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(TRAP_VEC_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       funct3,
   input  logic             is_branch,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic             Eq,
   input  logic             Lt,
   output logic             BrUn,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             br_taken,
   output logic             misalign_exc,
   output logic             illegal_br,
   output logic [31:0]      br_cnt,
   output logic [31:0]      br_taken_cnt
);

   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   state_e           state_q;
   logic             imem_req_q;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [31:0]      br_cnt_q, br_cnt_d;
   logic [31:0]      tk_cnt_q, tk_cnt_d;

   logic             br_v, jal_v, jalr_v;
   logic             cond_taken, cond_illegal;
   logic             in_exec, redirect, misalign;
   logic [WIDTH-1:0] base, sum, target;

   br_cond u_br_cond (
      .funct3_i  (funct3),
      .eq_i      (Eq),
      .lt_i      (Lt),
      .taken_o   (cond_taken),
      .illegal_o (cond_illegal)
   );

   // Class decode: anything not strictly one-hot is sequential
   always_comb begin
      br_v   = ({is_branch, is_jal, is_jalr} == 3'b100);
      jal_v  = ({is_branch, is_jal, is_jalr} == 3'b010);
      jalr_v = ({is_branch, is_jal, is_jalr} == 3'b001);
   end

   // Target and redirect resolution for the current instruction
   always_comb begin
      in_exec  = (state_q == S_EXEC);
      base     = jalr_v ? rs1_data : pc_q;
      sum      = base + imm;
      target   = jalr_v ? {sum[WIDTH-1:1], 1'b0} : sum;
      redirect = (br_v & cond_taken) | jal_v | jalr_v;
      misalign = redirect & target[1];
   end

   // Next PC and counter updates, only at the S_EXEC exit edge
   always_comb begin
      pc_d     = pc_q;
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      if (in_exec) begin
         if (misalign)
            pc_d = TRAP_VEC;
         else if (redirect)
            pc_d = target;
         else
            pc_d = pc_q + FOUR;
         if (br_v) begin
            br_cnt_d = sat_inc32(br_cnt_q);
            if (cond_taken)
               tk_cnt_d = sat_inc32(tk_cnt_q);
         end
      end
   end

   // Control FSM with registered fetch request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_BOOT;
         imem_req_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_BOOT: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  state_q    <= S_EXEC;
                  imem_req_q <= 1'b0;
               end
            end
            S_EXEC: begin
               if (misalign) begin
                  state_q    <= S_TRAP;
                  imem_req_q <= 1'b0;
               end else begin
                  state_q    <= S_FETCH;
                  imem_req_q <= 1'b1;
               end
            end
            S_TRAP: begin
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
            end
            default: begin
               state_q    <= S_BOOT;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // PC and performance counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_VEC;
         br_cnt_q <= 32'd0;
         tk_cnt_q <= 32'd0;
      end else begin
         pc_q     <= pc_d;
         br_cnt_q <= br_cnt_d;
         tk_cnt_q <= tk_cnt_d;
      end
   end

   // Output drive: per-instruction pulses only while in S_EXEC
   always_comb begin
      BrUn         = is_branch & funct3[1];
      imem_req     = imem_req_q;
      pc           = pc_q;
      pc_plus4     = pc_q + FOUR;
      br_taken     = in_exec & redirect;
      misalign_exc = in_exec & misalign;
      illegal_br   = in_exec & br_v & cond_illegal;
      br_cnt       = br_cnt_q;
      br_taken_cnt = tk_cnt_q;
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed and randomized checks of the
// branch/PC unit against a rule-level reference model.
module tb_branch_pc_unit;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic        is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
   logic [31:0] imm = 32'd0, rs1_data = 32'd0;
   logic        Eq = 1'b0, Lt = 1'b0;
   logic        BrUn, imem_req, imem_ready = 1'b0;
   logic [31:0] pc, pc_plus4, br_cnt, br_taken_cnt;
   logic        br_taken, misalign_exc, illegal_br;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] exp_pc, exp_brc, exp_btc;
   logic [31:0] m_cur, m_next;
   logic        m_taken, m_ill, m_mis, m_brun;

   logic        o_req, o_taken, o_ill, o_mis, o_brun;
   logic        o_req_after, o_mis_after, o_ill_after;
   logic [31:0] o_pc, o_p4, o_npc, o_brc, o_btc;

   branch_pc_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .funct3       (funct3),
      .is_branch    (is_branch),
      .is_jal       (is_jal),
      .is_jalr      (is_jalr),
      .imm          (imm),
      .rs1_data     (rs1_data),
      .Eq           (Eq),
      .Lt           (Lt),
      .BrUn         (BrUn),
      .imem_req     (imem_req),
      .imem_ready   (imem_ready),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .br_taken     (br_taken),
      .misalign_exc (misalign_exc),
      .illegal_br   (illegal_br),
      .br_cnt       (br_cnt),
      .br_taken_cnt (br_taken_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: RISC-V branch rules applied to the architectural PC
   function automatic void model(input logic [2:0] cls,
                                 input logic [2:0] f3,
                                 input logic [31:0] im,
                                 input logic [31:0] r1,
                                 input logic e, input logic l);
      logic        cond;
      logic        ill;
      logic [31:0] tgt;
      cond = 1'b0;
      ill  = 1'b0;
      case (f3)
         3'd0: cond = e;
         3'd1: cond = !e;
         3'd4, 3'd6: cond = l;
         3'd5, 3'd7: cond = !l;
         default: ill = 1'b1;
      endcase
      m_cur   = exp_pc;
      m_brun  = cls[2] & (f3 == 3'd2 || f3 == 3'd3 ||
                          f3 == 3'd6 || f3 == 3'd7);
      m_taken = 1'b0;
      m_ill   = 1'b0;
      tgt     = exp_pc + im;
      if (cls == 3'b100) begin
         if (exp_brc != 32'hFFFF_FFFF) exp_brc = exp_brc + 1;
         m_ill = ill;
         if (!ill && cond) begin
            m_taken = 1'b1;
            if (exp_btc != 32'hFFFF_FFFF) exp_btc = exp_btc + 1;
         end
      end else if (cls == 3'b010) begin
         m_taken = 1'b1;
      end else if (cls == 3'b001) begin
         m_taken = 1'b1;
         tgt = (r1 + im) & ~32'd1;
      end
      m_mis = m_taken && ((tgt % 4) >= 2);
      if (!m_taken) m_next = exp_pc + 4;
      else if (m_mis) m_next = TV;
      else m_next = tgt;
      exp_pc = m_next;
   endfunction

   // Drive one instruction through fetch and exec, capture outputs
   task automatic do_instr(input logic [2:0] cls, input logic [2:0] f3,
                           input logic [31:0] im, input logic [31:0] r1,
                           input logic e, input logic l);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      n_chk++;
      if (n >= 50) begin
         n_fail++;
         $display("FAIL fetch_wait imem_req=%b required 1", imem_req);
      end
      {is_branch, is_jal, is_jalr} = cls;
      funct3 = f3; imm = im; rs1_data = r1; Eq = e; Lt = l;
      imem_ready = 1'b1;
      model(cls, f3, im, r1, e, l);
      @(posedge clk); #1;
      imem_ready = 1'b0;
      o_req = imem_req; o_taken = br_taken; o_ill = illegal_br;
      o_mis = misalign_exc; o_brun = BrUn; o_pc = pc; o_p4 = pc_plus4;
      @(posedge clk); #1;
      o_npc = pc; o_brc = br_cnt; o_btc = br_taken_cnt;
      o_req_after = imem_req; o_mis_after = misalign_exc;
      o_ill_after = illegal_br;
      {is_branch, is_jal, is_jalr} = 3'b000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      is_jal = 1'b1;
      #3;
      n_chk++;
      if (pc !== RV) begin
         n_fail++; $display("FAIL reset_pc got %h want %h", pc, RV);
      end
      n_chk++;
      if ({imem_req, br_taken, misalign_exc, illegal_br} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000",
                  {imem_req, br_taken, misalign_exc, illegal_br});
      end
      n_chk++;
      if (br_cnt !== 32'd0 || br_taken_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_cnt got %h/%h want 0/0", br_cnt, br_taken_cnt);
      end
      is_jal = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      exp_pc = RV; exp_brc = 0; exp_btc = 0;
      #1;
      n_chk++;
      if (imem_req !== 1'b0) begin
         n_fail++; $display("FAIL req_cycle1 got %b want 0", imem_req);
      end
      @(posedge clk); #1;
      n_chk++;
      if (imem_req !== 1'b1) begin
         n_fail++; $display("FAIL req_cycle2 got %b want 1", imem_req);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         do_instr(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
         n_chk++;
         if (o_pc !== 32'(i * 4) || o_npc !== 32'(i * 4 + 4)) begin
            n_fail++;
            $display("FAIL seq_pc[%0d] got %h->%h want %h->%h", i,
                     o_pc, o_npc, i * 4, i * 4 + 4);
         end
         n_chk++;
         if (o_req !== 1'b0 || o_p4 !== o_pc + 32'd4) begin
            n_fail++;
            $display("FAIL seq_exec req=%b p4=%h want 0 %h", o_req, o_p4,
                     i * 4 + 4);
         end
      end
   endtask

   task automatic test_beq();
      do_instr(3'b010, 3'd0, 32'h40 - exp_pc, 32'd0, 1'b0, 1'b0);
      do_instr(3'b100, 3'd0, 32'h10, 32'd0, 1'b1, 1'b0);
      n_chk++;
      if (o_npc !== 32'h50 || o_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL beq_taken pc=%h tk=%b want 50 1", o_npc, o_taken);
      end
      n_chk++;
      if (o_brc !== 32'd1 || o_btc !== 32'd1) begin
         n_fail++;
         $display("FAIL beq_cnt got %0d/%0d want 1/1", o_brc, o_btc);
      end
      do_instr(3'b010, 3'd0, 32'h40 - exp_pc, 32'd0, 1'b0, 1'b0);
      do_instr(3'b100, 3'd0, 32'h10, 32'd0, 1'b0, 1'b0);
      n_chk++;
      if (o_npc !== 32'h44 || o_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL beq_nt pc=%h tk=%b want 44 0", o_npc, o_taken);
      end
      n_chk++;
      if (o_brc !== 32'd2 || o_btc !== 32'd1) begin
         n_fail++;
         $display("FAIL beq_nt_cnt got %0d/%0d want 2/1", o_brc, o_btc);
      end
   endtask

   task automatic test_bltu_bge();
      do_instr(3'b100, 3'b110, 32'h20, 32'd0, 1'b0, 1'b1);
      n_chk++;
      if (o_brun !== 1'b1 || o_taken !== 1'b1 || o_npc !== m_next) begin
         n_fail++;
         $display("FAIL bltu brun=%b tk=%b pc=%h want 1 1 %h",
                  o_brun, o_taken, o_npc, m_next);
      end
      do_instr(3'b100, 3'b101, 32'h20, 32'd0, 1'b0, 1'b1);
      n_chk++;
      if (o_brun !== 1'b0 || o_taken !== 1'b0 || o_npc !== o_pc + 32'd4) begin
         n_fail++;
         $display("FAIL bge brun=%b tk=%b pc=%h want 0 0 %h",
                  o_brun, o_taken, o_npc, o_pc + 32'd4);
      end
   endtask

   task automatic test_jalr_misalign();
      do_instr(3'b001, 3'd0, 32'h2, 32'h1001, 1'b0, 1'b0);
      n_chk++;
      if (o_mis !== 1'b1 || o_taken !== 1'b1 || o_npc !== 32'h100) begin
         n_fail++;
         $display("FAIL jalr_mis mis=%b tk=%b pc=%h want 1 1 100",
                  o_mis, o_taken, o_npc);
      end
      n_chk++;
      if (o_req_after !== 1'b0 || o_mis_after !== 1'b0) begin
         n_fail++;
         $display("FAIL trap_cycle req=%b mis=%b want 0 0",
                  o_req_after, o_mis_after);
      end
      @(posedge clk); #1;
      n_chk++;
      if (imem_req !== 1'b1) begin
         n_fail++; $display("FAIL trap_exit req=%b want 1", imem_req);
      end
   endtask

   task automatic test_illegal();
      do_instr(3'b100, 3'b010, 32'h80, 32'd0, 1'b1, 1'b1);
      n_chk++;
      if (o_ill !== 1'b1 || o_taken !== 1'b0 || o_npc !== o_pc + 32'd4) begin
         n_fail++;
         $display("FAIL illegal ill=%b tk=%b pc=%h want 1 0 %h",
                  o_ill, o_taken, o_npc, o_pc + 32'd4);
      end
      n_chk++;
      if (o_ill_after !== 1'b0) begin
         n_fail++; $display("FAIL illegal_pulse got %b want 0", o_ill_after);
      end
   endtask

   task automatic test_non_onehot();
      do_instr(3'b110, 3'd0, 32'h80, 32'd0, 1'b1, 1'b0);
      n_chk++;
      if (o_taken !== 1'b0 || o_mis !== 1'b0 || o_ill !== 1'b0 ||
          o_npc !== o_pc + 32'd4) begin
         n_fail++;
         $display("FAIL non_onehot tk=%b mis=%b ill=%b pc=%h want 0 0 0 %h",
                  o_taken, o_mis, o_ill, o_npc, o_pc + 32'd4);
      end
   endtask

   task automatic test_stall();
      int bad;
      bad = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (pc !== exp_pc || imem_req !== 1'b1) begin
            n_fail++; bad++;
            $display("FAIL stall[%0d] pc=%h req=%b want %h 1",
                     i, pc, imem_req, exp_pc);
         end
      end
      do_instr(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      n_chk++;
      if (o_npc !== m_next) begin
         n_fail++; $display("FAIL stall_exit pc=%h want %h", o_npc, m_next);
      end
   endtask

   task automatic test_reset_mid_exec();
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      {is_branch, is_jal, is_jalr} = 3'b100;
      funct3 = 3'd0; imm = 32'h40; Eq = 1'b1;
      imem_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (pc !== RV || br_cnt !== 32'd0 || br_taken_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_mid pc=%h cnt=%0d/%0d want %h 0/0",
                  pc, br_cnt, br_taken_cnt, RV);
      end
      n_chk++;
      if (imem_req !== 1'b0 || br_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_flags req=%b tk=%b want 0 0",
                  imem_req, br_taken);
      end
      imem_ready = 1'b0;
      {is_branch, is_jal, is_jalr} = 3'b000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_pc = RV; exp_brc = 0; exp_btc = 0;
      do_instr(3'b000, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      n_chk++;
      if (o_pc !== RV || o_brc !== 32'd0 || o_btc !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_restart pc=%h cnt=%0d/%0d want %h 0/0",
                  o_pc, o_brc, o_btc, RV);
      end
   endtask

   task automatic test_random();
      logic [2:0]  cls, f3;
      logic [31:0] im, r1;
      int          sel;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0: cls = 3'b000;
            1, 2: cls = 3'b100;
            3: cls = 3'b010;
            4: cls = 3'b001;
            default: cls = 3'($urandom);
         endcase
         f3 = 3'($urandom);
         im = 32'($urandom_range(0, 255)) * 4;
         if ($urandom_range(0, 1) == 1) im = -im;
         if ($urandom_range(0, 7) == 0) im = im | 32'd2;
         r1 = $urandom;
         if ($urandom_range(0, 1) == 1) r1 = r1 & ~32'd2;
         do_instr(cls, f3, im, r1, 1'($urandom), 1'($urandom));
         n_chk++;
         if ({o_taken, o_ill, o_mis, o_brun} !==
             {m_taken, m_ill, m_mis, m_brun}) begin
            n_fail++;
            $display("FAIL rnd_flags[%0d] tk/ill/mis/brun got %b want %b",
                     i, {o_taken, o_ill, o_mis, o_brun},
                     {m_taken, m_ill, m_mis, m_brun});
         end
         n_chk++;
         if (o_pc !== m_cur || o_npc !== m_next) begin
            n_fail++;
            $display("FAIL rnd_pc[%0d] got %h->%h want %h->%h",
                     i, o_pc, o_npc, m_cur, m_next);
         end
         n_chk++;
         if (o_brc !== exp_brc || o_btc !== exp_btc) begin
            n_fail++;
            $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d",
                     i, o_brc, o_btc, exp_brc, exp_btc);
         end
      end
   endtask

   initial begin
      exp_pc = RV; exp_brc = 0; exp_btc = 0;
      test_reset();
      test_sequential();
      test_beq();
      test_bltu_bge();
      test_jalr_misalign();
      test_illegal();
      test_non_onehot();
      test_stall();
      test_random();
      test_reset_mid_exec();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
